mem_access_stage: RTL and testbench

- MEM-stage data-memory access unit, between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Executes byte/half/word loads and stores against a data memory that uses a req/ack handshake.
- Stalls the front of the pipeline while an access is in flight.
- Presents WB control, load data, ALU result and destination register to MEM/WB.

---
 rtl/mem_access_stage_if.sv | 21 ++
 rtl/mem_access_stage.sv | 179 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage and data memory.
// The stage is the master; the memory model or SRAM wrapper is the slave.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// MEM-stage load/store unit: req/ack data-memory access with timeout abort.
// Optional MEM_MISALIGN_TRAP_EN faults misaligned half/word ops without a bus access.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  WB_X,
    input  logic        MemRead_X,
    input  logic        MemWrite_X,
    input  logic [1:0]  MemSize_X,
    input  logic        MemUnsigned_X,
    input  logic [31:0] ALUOut_X,
    input  logic [31:0] WriteData_X,
    input  logic [4:0]  WriteReg_X,
    output logic [1:0]  WB_M,
    output logic [31:0] ReadData_M,
    output logic [31:0] ALUOut_M,
    output logic [4:0]  WriteReg_M,
    output logic        Stall_M,
    output logic        Fault_M,
    mem_access_stage_if.master dmem
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_fault;
    logic [31:0] r_rdata;

    logic        w_mem;
    logic        w_st;
    logic [1:0]  w_a;
    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;
    logic [7:0]  w_cnt_nx;

    assign w_mem    = MemRead_X | MemWrite_X;
    assign w_st     = MemWrite_X;
    assign w_a      = ALUOut_X[1:0];
    assign w_cnt_nx = r_cnt + 8'd1;

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_mis = ((MemSize_X == 2'b01) & w_a[0]) |
                   (MemSize_X[1] & (w_a != 2'b00));
`else
    assign w_mis = 1'b0;
`endif

    // Loads always enable all lanes; the lane is picked on return.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteData_X;
        if (w_st) begin
            unique case (MemSize_X)
                2'b00: begin
                    w_be    = 4'b0001 << w_a;
                    w_wdata = {4{WriteData_X[7:0]}};
                end
                2'b01: begin
                    w_be    = w_a[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{WriteData_X[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = WriteData_X;
                end
            endcase
        end
    end

    always_comb begin
        unique case (w_a)
            2'b00:   w_byte = dmem.dmem_rdata[7:0];
            2'b01:   w_byte = dmem.dmem_rdata[15:8];
            2'b10:   w_byte = dmem.dmem_rdata[23:16];
            default: w_byte = dmem.dmem_rdata[31:24];
        endcase
        w_half = w_a[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
        unique case (MemSize_X)
            2'b00:   w_ld = {{24{~MemUnsigned_X & w_byte[7]}}, w_byte};
            2'b01:   w_ld = {{16{~MemUnsigned_X & w_half[15]}}, w_half};
            default: w_ld = dmem.dmem_rdata;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= 8'd0;
            r_fault         <= 1'b0;
            r_rdata         <= 32'd0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'd0;
            dmem.dmem_be    <= 4'd0;
            dmem.dmem_wdata <= 32'd0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_mem) begin
                        if (w_mis) begin
                            r_fault <= 1'b1;
                            r_rdata <= 32'd0;
                            r_state <= S_DONE;
                        end else begin
                            dmem.dmem_req   <= 1'b1;
                            dmem.dmem_we    <= w_st;
                            dmem.dmem_addr  <= {ALUOut_X[31:2], 2'b00};
                            dmem.dmem_be    <= w_be;
                            dmem.dmem_wdata <= w_wdata;
                            r_cnt           <= 8'd0;
                            r_state         <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    r_cnt <= w_cnt_nx;
                    if (dmem.dmem_ack) begin
                        r_rdata       <= w_st ? 32'd0 : w_ld;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        r_state       <= S_DONE;
                    end else if (w_cnt_nx == 8'(TIMEOUT)) begin
                        r_rdata       <= 32'd0;
                        r_fault       <= 1'b1;
                        dmem.dmem_req <= 1'b0;
                        dmem.dmem_we  <= 1'b0;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_cnt   <= 8'd0;
                    r_fault <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ALUOut_M   = ALUOut_X;
    assign WriteReg_M = WriteReg_X;

    always_comb begin
        WB_M       = WB_X;
        ReadData_M = 32'd0;
        Stall_M    = 1'b0;
        Fault_M    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_mem) begin
                    Stall_M = 1'b1;
                    WB_M    = 2'b00;
                end
            end
            S_REQ: begin
                Stall_M = 1'b1;
                WB_M    = 2'b00;
            end
            S_DONE: begin
                ReadData_M = r_rdata;
                WB_M       = r_fault ? 2'b00 : WB_X;
                Fault_M    = r_fault;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a per-cycle behavioural model.
// Honours MEM_MISALIGN_TRAP_EN in the model when the macro is defined.
module tb_mem_access_stage;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  WB_X;
    logic        MemRead_X;
    logic        MemWrite_X;
    logic [1:0]  MemSize_X;
    logic        MemUnsigned_X;
    logic [31:0] ALUOut_X;
    logic [31:0] WriteData_X;
    logic [4:0]  WriteReg_X;
    logic [1:0]  WB_M;
    logic [31:0] ReadData_M;
    logic [31:0] ALUOut_M;
    logic [4:0]  WriteReg_M;
    logic        Stall_M;
    logic        Fault_M;

    mem_access_stage_if bus ();

    mem_access_stage #(.TIMEOUT(TO)) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .WB_X          (WB_X),
        .MemRead_X     (MemRead_X),
        .MemWrite_X    (MemWrite_X),
        .MemSize_X     (MemSize_X),
        .MemUnsigned_X (MemUnsigned_X),
        .ALUOut_X      (ALUOut_X),
        .WriteData_X   (WriteData_X),
        .WriteReg_X    (WriteReg_X),
        .WB_M          (WB_M),
        .ReadData_M    (ReadData_M),
        .ALUOut_M      (ALUOut_M),
        .WriteReg_M    (WriteReg_M),
        .Stall_M       (Stall_M),
        .Fault_M       (Fault_M),
        .dmem          (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        ev = 1'b0;
    logic        exp_stall;
    logic [1:0]  exp_wb;
    logic [31:0] exp_rd;
    logic        exp_fault;
    logic        exp_req;
    logic        exp_bus;
    logic        exp_we;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic logic [3:0] m_be(input logic wr, input logic [1:0] sz,
                                        input int a);
        if (!wr) return 4'b1111;
        if (sz == 2'b00) return 4'(1 << a);
        if (sz == 2'b01) return (a >= 2) ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz,
                                            input logic [31:0] d);
        if (sz == 2'b00) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                           input int a, input logic [31:0] w);
        logic [31:0] v;
        if (sz == 2'b00) begin
            v = (w >> (8 * a)) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 2'b01) begin
            v = (w >> ((a >= 2) ? 16 : 0)) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic m_mis(input logic [1:0] sz, input int a);
`ifdef MEM_MISALIGN_TRAP_EN
        if (sz == 2'b01) return (a % 2) != 0;
        if (sz >= 2'b10) return a != 0;
        return 1'b0;
`else
        return (sz == 2'b11) && (a == 99);
`endif
    endfunction

    always @(negedge clk) begin
        if (ev) begin
            cmp("stall", 32'(Stall_M), 32'(exp_stall));
            cmp("wb", 32'(WB_M), 32'(exp_wb));
            cmp("rdata_m", ReadData_M, exp_rd);
            cmp("fault", 32'(Fault_M), 32'(exp_fault));
            cmp("req", 32'(bus.dmem_req), 32'(exp_req));
            cmp("alu_m", ALUOut_M, ALUOut_X);
            cmp("wreg_m", 32'(WriteReg_M), 32'(WriteReg_X));
            if (exp_bus) begin
                cmp("we", 32'(bus.dmem_we), 32'(exp_we));
                cmp("addr", bus.dmem_addr, exp_addr);
                cmp("be", 32'(bus.dmem_be), 32'(exp_be));
                cmp("wdata", bus.dmem_wdata, exp_wdata);
            end
        end
    end

    logic [31:0] d_rd;
    logic        d_fault;
    logic [1:0]  d_wb;

    task automatic step();
        @(negedge clk);
        d_rd    = ReadData_M;
        d_fault = Fault_M;
        d_wb    = WB_M;
        @(posedge clk);
        #1;
    endtask

    // dly: REQ cycles before ack (0 = first REQ cycle), negative = never.
    task automatic run_op(input logic [1:0] wb, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          input logic [4:0] wreg, input int dly,
                          input logic [31:0] rdata);
        int  a;
        int  n;
        logic ok;
        a             = int'(addr[1:0]);
        WB_X          = wb;
        MemRead_X     = rd;
        MemWrite_X    = wr;
        MemSize_X     = sz;
        MemUnsigned_X = uns;
        ALUOut_X      = addr;
        WriteData_X   = wd;
        WriteReg_X    = wreg;
        bus.dmem_ack  = 1'b0;
        ev            = 1'b1;
        exp_bus       = 1'b0;
        exp_req       = 1'b0;
        exp_fault     = 1'b0;
        exp_rd        = 32'd0;
        if (!(rd | wr)) begin
            exp_stall = 1'b0;
            exp_wb    = wb;
            step();
            return;
        end
        exp_stall = 1'b1;
        exp_wb    = 2'b00;
        step();
        if (m_mis(sz, a)) begin
            exp_stall = 1'b0;
            exp_fault = 1'b1;
            exp_wb    = 2'b00;
            step();
            return;
        end
        ok = (dly >= 0) && (dly < TO);
        n  = ok ? dly + 1 : TO;
        exp_bus   = 1'b1;
        exp_req   = 1'b1;
        exp_we    = wr;
        exp_addr  = addr & 32'hFFFF_FFFC;
        exp_be    = m_be(wr, sz, a);
        exp_wdata = wr ? m_wdata(sz, wd) : wd;
        for (int k = 0; k < n; k++) begin
            if (ok && k == n - 1) begin
                bus.dmem_ack   = 1'b1;
                bus.dmem_rdata = rdata;
            end else begin
                bus.dmem_ack   = 1'b0;
                bus.dmem_rdata = $urandom;
            end
            step();
        end
        bus.dmem_ack = 1'b0;
        exp_bus   = 1'b0;
        exp_req   = 1'b0;
        exp_stall = 1'b0;
        exp_fault = !ok;
        exp_wb    = ok ? wb : 2'b00;
        exp_rd    = (ok && !wr) ? m_load(sz, uns, a, rdata) : 32'd0;
        step();
    endtask

    initial begin
        rst_n          = 1'b0;
        WB_X           = 2'b00;
        MemRead_X      = 1'b0;
        MemWrite_X     = 1'b0;
        MemSize_X      = 2'b00;
        MemUnsigned_X  = 1'b0;
        ALUOut_X       = 32'd0;
        WriteData_X    = 32'd0;
        WriteReg_X     = 5'd0;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = 32'd0;
        #2;
        cmp("rst_stall", 32'(Stall_M), 32'd0);
        cmp("rst_req", 32'(bus.dmem_req), 32'd0);
        cmp("rst_we", 32'(bus.dmem_we), 32'd0);
        cmp("rst_be", 32'(bus.dmem_be), 32'd0);
        cmp("rst_addr", bus.dmem_addr, 32'd0);
        cmp("rst_wdata", bus.dmem_wdata, 32'd0);
        cmp("rst_fault", 32'(Fault_M), 32'd0);
        cmp("rst_rdata", ReadData_M, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        run_op(2'b11, 1, 0, 2'b10, 0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
        cmp("lw_lit", d_rd, 32'hDEADBEEF);
        cmp("lw_wb_lit", 32'(d_wb), 32'd3);
        cmp("lw_be_lit", 32'(bus.dmem_be), 32'hF);
        cmp("lw_addr_lit", bus.dmem_addr, 32'h100);

        run_op(2'b01, 1, 0, 2'b00, 0, 32'h103, 32'h0, 5'd6, 0, 32'h80112233);
        cmp("lb_lit", d_rd, 32'hFFFFFF80);
        run_op(2'b01, 1, 0, 2'b00, 1, 32'h103, 32'h0, 5'd6, 1, 32'h80112233);
        cmp("lbu_lit", d_rd, 32'h00000080);

        run_op(2'b00, 0, 1, 2'b01, 0, 32'h202, 32'h1234A5A5, 5'd0, 1, 32'hFFFF);
        cmp("sh_lit_rd", d_rd, 32'd0);
        cmp("sh_lit_be", 32'(bus.dmem_be), 32'hC);
        cmp("sh_lit_addr", bus.dmem_addr, 32'h200);
        cmp("sh_lit_wd", bus.dmem_wdata, 32'hA5A5A5A5);

        run_op(2'b10, 1, 0, 2'b01, 0, 32'h102, 32'h0, 5'd7, 2, 32'h80010000);
        cmp("lh_lit", d_rd, 32'hFFFF8001);
        run_op(2'b10, 1, 0, 2'b01, 1, 32'h100, 32'h0, 5'd8, 0, 32'h1234ABCD);
        cmp("lhu_lit", d_rd, 32'h0000ABCD);
        run_op(2'b01, 1, 0, 2'b00, 0, 32'h100, 32'h0, 5'd9, 0, 32'h1234567F);
        run_op(2'b00, 0, 1, 2'b00, 0, 32'h301, 32'hFFFF_FFAB, 5'd0, 0, 32'h0);
        cmp("sb_lit_wd", bus.dmem_wdata, 32'hABABABAB);
        cmp("sb_lit_be", 32'(bus.dmem_be), 32'h2);
        run_op(2'b00, 0, 1, 2'b10, 0, 32'h400, 32'hCAFEF00D, 5'd0, 0, 32'h0);
        run_op(2'b11, 1, 1, 2'b00, 0, 32'h503, 32'h77, 5'd3, 0, 32'h11223344);
        run_op(2'b10, 0, 0, 2'b00, 0, 32'h1234, 32'h0, 5'd4, 0, 32'h0);

        run_op(2'b11, 1, 0, 2'b10, 0, 32'h600, 32'h0, 5'd10, -1, 32'h0);
        cmp("to_fault_lit", 32'(d_fault), 32'd1);
        cmp("to_wb_lit", 32'(d_wb), 32'd0);
        run_op(2'b11, 1, 0, 2'b10, 0, 32'h604, 32'h0, 5'd11, TO - 1, 32'h55AA);
        cmp("late_ack_lit", d_rd, 32'h55AA);

        run_op(2'b11, 1, 0, 2'b10, 0, 32'h101, 32'h0, 5'd12, 0, 32'h89ABCDEF);
`ifdef MEM_MISALIGN_TRAP_EN
        cmp("mis_fault_lit", 32'(d_fault), 32'd1);
`else
        cmp("mis_rd_lit", d_rd, 32'h89ABCDEF);
`endif
        run_op(2'b01, 0, 1, 2'b01, 0, 32'h703, 32'hBEEF, 5'd0, 0, 32'h0);
        run_op(2'b00, 0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd1, 0, 32'h0);

        ev            = 1'b0;
        WB_X          = 2'b11;
        MemRead_X     = 1'b1;
        MemWrite_X    = 1'b0;
        MemSize_X     = 2'b10;
        ALUOut_X      = 32'h800;
        @(posedge clk);
        #1;
        cmp("mid_req", 32'(bus.dmem_req), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        cmp("arst_req", 32'(bus.dmem_req), 32'd0);
        cmp("arst_stall_op", 32'(Stall_M), 32'd1);
        cmp("arst_wb_op", 32'(WB_M), 32'd0);
        MemRead_X = 1'b0;
        WB_X      = 2'b10;
        #1;
        cmp("arst_stall_nop", 32'(Stall_M), 32'd0);
        cmp("arst_wb_nop", 32'(WB_M), 32'd2);
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        cmp("late_stall", 32'(Stall_M), 32'd0);
        cmp("late_req", 32'(bus.dmem_req), 32'd0);
        @(posedge clk);
        #1;
        bus.dmem_ack = 1'b0;
        @(negedge clk);
        cmp("late_rd", ReadData_M, 32'd0);
        cmp("late_fault", 32'(Fault_M), 32'd0);
        cmp("late_wb", 32'(WB_M), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
